// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

  localparam int INSTR_W        = 32;
  localparam int PC_W           = 32;
  localparam int DEFAULT_ROM_AW = 10;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } ifetch_state_t;

endpackage

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, reads the instruction ROM and presents
// each fetched word with its PC in a valid/ready slot for decode.
// Redirects flush the slot; fetching past ROM space raises a pending fault.
// Optional build macro IFETCH_ALIGN_CHECK_EN: a redirect to a non-word-aligned
// target enters the fault state instead of fetching.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              ROM_AW   = DEFAULT_ROM_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ROM_AW-1:0]  rom_addr,
  output logic               rom_sel,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               fault
);

  ifetch_state_t   state;
  ifetch_state_t   state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next;
  logic            valid_next;
  logic            capture;
  logic            load;
  logic            in_range;

  // ROM request: read whenever running, the slot can take a word and the PC is inside ROM space.
  always_comb begin
    load     = !out_valid | out_ready;
    in_range = ((pc >> (ROM_AW + 2)) == '0);
    rom_addr = pc[ROM_AW+1:2];
    rom_sel  = (state == RUN) && load && in_range;
    capture  = rom_sel && !redirect_valid;
    fault    = (state == FAULT);
  end

  // Next state, next PC and slot occupancy; a redirect overrides everything else.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = out_valid;
    if (redirect_valid) begin
      pc_next    = redirect_pc;
      valid_next = 1'b0;
      state_next = RUN;
`ifdef IFETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_next = FAULT;
      end
`endif
    end else begin
      case (state)
        BOOT: begin
          state_next = RUN;
        end
        RUN: begin
          if (load) begin
            if (in_range) begin
              valid_next = 1'b1;
              pc_next    = pc + 32'd4;
            end else begin
              valid_next = 1'b0;
              state_next = FAULT;
            end
          end
        end
        FAULT: begin
          valid_next = 1'b0;
        end
        default: begin
          state_next = BOOT;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // PC and output slot; the slot payload only changes when a ROM word is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      pc        <= pc_next;
      out_valid <= valid_next;
      if (capture) begin
        out_instr <= rom_data;
        out_pc    <= pc;
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by random
// redirect/back-pressure traffic, compared against a behavioural fetch model.
module tb_ifetch;

  localparam int ROM_AW    = 10;
  localparam int ROM_WORDS = 1 << ROM_AW;
  localparam int ROM_BYTES = ROM_WORDS * 4;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_sel;
  logic [31:0]       rom_data;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              fault;

  logic [31:0] rom [0:ROM_WORDS-1];

  int checks = 0;
  int errors = 0;

  // Behavioural model of the fetch stage.
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_fault;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_opc;

  ifetch #(
    .RESET_PC (32'h0000_0000),
    .ROM_AW   (ROM_AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_sel        (rom_sel),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = rom_sel ? rom[rom_addr] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pc    = 32'h0;
    m_boot  = 1'b1;
    m_fault = 1'b0;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_opc   = 32'h0;
  endtask

  task automatic modelEdge(input logic rv, input logic [31:0] rpc, input logic rdy);
    if (rv) begin
      m_pc    = rpc;
      m_valid = 1'b0;
      m_boot  = 1'b0;
      m_fault = ALIGN && ((rpc % 4) != 0);
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_fault && (!m_valid || rdy)) begin
      if (m_pc < ROM_BYTES) begin
        m_instr = rom[m_pc / 4];
        m_opc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end else begin
        m_fault = 1'b1;
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic checkOutput();
    logic exp_sel;
    exp_sel = !m_boot && !m_fault && (!m_valid || out_ready) && (m_pc < ROM_BYTES);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("fault",     32'(fault),     32'(m_fault));
    chk("rom_sel",   32'(rom_sel),   32'(exp_sel));
    chk("rom_addr",  32'(rom_addr),  32'((m_pc / 4) % ROM_WORDS));
    if (m_valid) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_pc",    out_pc,    m_opc);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    checkOutput();
    @(posedge clk);
    modelEdge(rv, rpc, rdy);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_fault", 32'(fault), 32'h0);
    modelReset();
    checkOutput();
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    int          pick;

    for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
    rom[0] = 32'h11;
    rom[1] = 32'h22;
    rom[2] = 32'h33;
    rom[3] = 32'h44;

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    modelReset();

    // Reset values, held across one clock edge.
    #2;
    checkOutput();
    chk("reset_instr", out_instr, 32'h0);
    chk("reset_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;

    // Boot, then straight-line fetch of the first words.
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("boot_no_valid", 32'(out_valid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("first_instr", out_instr, 32'h11);
    chk("first_pc", out_pc, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("second_instr", out_instr, 32'h22);
    chk("second_pc", out_pc, 32'h4);

    // Back-pressure for three cycles, then release.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      chk("stall_instr", out_instr, 32'h22);
      chk("stall_pc", out_pc, 32'h4);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("after_stall_instr", out_instr, 32'h33);
    chk("after_stall_pc", out_pc, 32'h8);

    // Redirect while decode is stalled on PC 0x8: slot flushed, target one edge later.
    applyStimulus(1'b1, 32'h100, 1'b0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("redir_valid", 32'(out_valid), 32'h1);
    chk("redir_pc", out_pc, 32'h100);
    chk("redir_instr", out_instr, rom[32'h40]);

    // Run off the end of ROM space, then recover with a redirect to 0.
    applyStimulus(1'b1, 32'hFF8, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("top_pc0", out_pc, 32'hFF8);
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("top_pc1", out_pc, 32'hFFC);
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("oob_fault", 32'(fault), 32'h1);
    chk("oob_valid", 32'(out_valid), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h0, 1'b1);
    chk("recover_fault", 32'(fault), 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("recover_pc", out_pc, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Asynchronous reset in the middle of a stream, then reboot.
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("reboot_pc", out_pc, 32'h0);

    // Asynchronous reset while a fault is pending.
    applyStimulus(1'b1, 32'h2000, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    chk("pre_rst_fault", 32'(fault), 32'h1);
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Unaligned redirect target.
    applyStimulus(1'b1, 32'h102, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    if (ALIGN) begin
      chk("align_fault", 32'(fault), 32'h1);
      chk("align_valid", 32'(out_valid), 32'h0);
    end else begin
      chk("unaligned_pc", out_pc, 32'h102);
      chk("unaligned_instr", out_instr, rom[32'h40]);
    end

    // Random redirects and back-pressure.
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      case (pick)
        6:       rpc = 32'hFF0 + {$urandom_range(0, 3), 2'b00};
        7:       rpc = 32'($urandom_range(0, ROM_BYTES - 1));
        8:       rpc = $urandom;
        9:       rpc = 32'hFFFF_FFF8;
        default: rpc = {20'h0, 10'($urandom_range(0, ROM_WORDS - 1)), 2'b00};
      endcase
      applyStimulus(($urandom_range(0, 7) == 0), rpc, ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
